// File: rtl/apb_master_ctrl_if.sv
// Command/response handshake plus APB3 bus signals for apb_master_ctrl.
// The master modport is the controller's view; slave is the opposite side.
interface apb_master_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB3 master: one command becomes one IDLE->SETUP->ACCESS transfer with a
// single-cycle response pulse carrying read data, slave error and timeout.
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               preset,
  apb_master_ctrl_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic              pwrite_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              rsp_err_nxt;
  logic              rsp_timeout_nxt;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.psel      = (state != IDLE);
  assign bus.penable   = (state == ACCESS);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.paddr       <= '0;
      bus.pwrite      <= 1'b0;
      bus.pwdata      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bus.paddr       <= paddr_nxt;
      bus.pwrite      <= pwrite_nxt;
      bus.pwdata      <= pwdata_nxt;
      bus.rsp_valid   <= rsp_valid_nxt;
      bus.rsp_rdata   <= rsp_rdata_nxt;
      bus.rsp_err     <= rsp_err_nxt;
      bus.rsp_timeout <= rsp_timeout_nxt;
    end
  end

  // Response fields default to zero so they are only non-zero on the pulse.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    paddr_nxt       = bus.paddr;
    pwrite_nxt      = bus.pwrite;
    pwdata_nxt      = bus.pwdata;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = '0;
    rsp_err_nxt     = 1'b0;
    rsp_timeout_nxt = 1'b0;

    case (state)
      IDLE: begin
        paddr_nxt  = '0;
        pwrite_nxt = 1'b0;
        pwdata_nxt = '0;
        if (bus.cmd_valid) begin
          paddr_nxt  = bus.cmd_addr;
          pwrite_nxt = bus.cmd_write;
          pwdata_nxt = bus.cmd_write ? bus.cmd_wdata : '0;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        cnt_nxt   = '0;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = bus.pslverr;
          rsp_rdata_nxt = bus.pwrite ? '0 : bus.prdata;
          state_nxt     = IDLE;
        end else if ((TIMEOUT > 0) && (cnt == LIMIT)) begin
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (state_nxt == IDLE) begin
          paddr_nxt  = '0;
          pwrite_nxt = 1'b0;
          pwdata_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- Parametrised APB3 master that turns a valid/ready command request into one APB transfer (IDLE -> SETUP -> ACCESS).
- Returns a single-cycle response pulse carrying read data, slave error and a timeout flag.
- Adds over the previous master:
  - configurable address and data widths
  - a command handshake instead of hard-coded address/data
  - PSLVERR capture
  - a wait-state timeout watchdog
- Sits between a local controller and an APB interconnect/slave.

Parameters:
- ADDR_W, 8, width of cmd_addr/paddr.
- DATA_W, 8, width of cmd_wdata/pwdata/prdata/rsp_rdata.
- TIMEOUT, 16, max consecutive ACCESS cycles with pready=0 before abort; 0 disables the watchdog. Counter width is clog2(TIMEOUT+1), minimum 1.

Ports:
- pclk  in  1  clock, all logic on rising edge
- preset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
- rsp_err  out  1  pslverr at completion, or timeout
- rsp_timeout  out  1  transfer aborted by watchdog
- psel  out  1  APB select
- penable  out  1  APB enable
- paddr  out  ADDR_W  APB address
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset (preset=1 at an edge):
  - state=IDLE
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0
  - cmd_ready = 1 once state is IDLE
  - wait counter = 0
- Reset mid-transfer: aborts at that edge; no rsp_valid pulse is generated.
- States: IDLE, SETUP, ACCESS (2-bit encoding). psel, penable and cmd_ready are decoded from state only (Moore):
  - IDLE: psel=0, penable=0, cmd_ready=1
  - SETUP: psel=1, penable=0, cmd_ready=0
  - ACCESS: psel=1, penable=1, cmd_ready=0
- IDLE:
  - On cmd_valid & cmd_ready at an edge, latch cmd_write, cmd_addr and cmd_wdata (wdata forced to 0 for reads) into paddr/pwrite/pwdata, then go to SETUP.
  - With no request, stay in IDLE.
- SETUP: always lasts exactly one cycle, then ACCESS. Clear the wait counter.
- ACCESS:
  - pready=1: the transfer completes at that edge.
    - rsp_valid=1 for the next cycle only.
    - rsp_err=pslverr, rsp_timeout=0.
    - rsp_rdata=prdata for reads, 0 for writes.
    - Next state IDLE.
  - pready=0 and (TIMEOUT=0 or counter<TIMEOUT-1): increment the counter and stay in ACCESS.
  - pready=0 and TIMEOUT>0 and counter==TIMEOUT-1: abort at that edge.
    - rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - Next state IDLE.
  - pready=1 on the same cycle the limit is reached: normal completion wins.
- paddr, pwrite and pwdata hold constant from SETUP through the last ACCESS cycle. They return to 0 in IDLE.
- rsp_* fields are 0 whenever rsp_valid=0.
- Response has no backpressure; the requester must sample on the pulse.
- Latency:
  - Command accepted at edge k → SETUP after edge k, ACCESS after edge k+1.
  - Zero-wait completion at edge k+2, rsp_valid high after edge k+2; cmd_ready=1 in that same cycle.
  - Peak throughput is one transfer per 3 cycles; each wait state adds 1 cycle.
- Command inputs are ignored outside IDLE. cmd_valid held high in IDLE at the rsp_valid cycle is accepted at that edge.

Test Plan:
- Zero-wait write: cmd write addr=0x32 wdata=0xA5, pready=1 → psel 1 for 2 cycles, penable 1 for 1 cycle; paddr=0x32, pwrite=1, pwdata=0xA5 stable throughout; rsp_valid 1 cycle later, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: cmd read addr=0x10, pready low 3 ACCESS cycles then high with prdata=0x5C → ACCESS lasts 4 cycles, rsp_rdata=0x5C, rsp_err=0, pwdata=0.
- Slave error: write, pready=1 with pslverr=1 → rsp_err=1, rsp_timeout=0, master returns to IDLE.
- Timeout with TIMEOUT=4: pready held 0 → exactly 4 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready rising on the 4th cycle → normal completion, rsp_timeout=0.
- Back-to-back: cmd_valid held high with 2 queued commands, pready=1 → second accepted in the rsp_valid cycle, 3-cycle spacing between SETUP phases.
- Reset mid-ACCESS: assert preset while pready=0 → next cycle psel=penable=0, cmd_ready=1, no rsp_valid; a subsequent read completes normally.
